// File: rtl/regfile_read_ctrl.sv
// Eight-entry register file with a pending-write scoreboard and a request/response
// read port that waits out RAW hazards, with writeback bypass into the captured result.
module regfile_read_ctrl #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issueValid,
  input  logic [2:0]        issueReg,
  input  logic              writeEnable,
  input  logic [2:0]        writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic              rdReqValid,
  output logic              rdReqReady,
  input  logic [2:0]        rdReg1,
  input  logic [2:0]        rdReg2,
  output logic              rdRespValid,
  input  logic              rdRespReady,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic [7:0]        busy,
  output logic [7:0]        stallCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [8];
  logic [2:0]        src1_p0;
  logic [2:0]        src2_p0;
  logic [7:0]        set_mask;
  logic [7:0]        clr_mask;
  logic              hit1;
  logic              hit2;
  logic              rdy1;
  logic              rdy2;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Register file storage: writeback is accepted in every FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (writeEnable) begin
      regs[writeReg] <= writeData;
    end
  end

  // Scoreboard: a set in the same cycle as a clear of that index wins.
  assign set_mask = issueValid  ? (8'd1 << issueReg) : 8'd0;
  assign clr_mask = writeEnable ? (8'd1 << writeReg) : 8'd0;

  always_ff @(posedge clk) begin
    if (rst) busy <= 8'h00;
    else     busy <= (busy & ~clr_mask) | set_mask;
  end

  // Readiness uses the registered busy bits only, so a same-cycle issue is invisible here.
  assign hit1 = writeEnable && (writeReg == src1_p0);
  assign hit2 = writeEnable && (writeReg == src2_p0);
  assign rdy1 = !busy[src1_p0] || hit1;
  assign rdy2 = !busy[src2_p0] || hit2;

  // Source indices latched on accept; held as data, so not reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && rdReqValid) begin
      src1_p0 <= rdReg1;
      src2_p0 <= rdReg2;
    end
  end

  // Control FSM with registered handshake outputs and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rdReqReady  <= 1'b1;
      rdRespValid <= 1'b0;
      stallCount  <= 8'd0;
      readData1   <= '0;
      readData2   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rdReqValid) begin
            state      <= WAIT;
            rdReqReady <= 1'b0;
          end
        end
        WAIT: begin
          if (rdy1 && rdy2) begin
            readData1   <= hit1 ? writeData : regs[src1_p0];
            readData2   <= hit2 ? writeData : regs[src2_p0];
            state       <= RESP;
            rdRespValid <= 1'b1;
          end else begin
            stallCount <= sat_inc(stallCount);
          end
        end
        RESP: begin
          if (rdRespReady) begin
            state       <= IDLE;
            rdRespValid <= 1'b0;
            rdReqReady  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          rdReqReady  <= 1'b1;
          rdRespValid <= 1'b0;
        end
      endcase
    end
  end

endmodule
